tcdm_dummy_memory: RTL and testbench

Multi-port word-addressed TCDM memory model used as the data, instruction and stack memory around the RedMulE complex. It serves MP independent request/grant ports with a fixed single-cycle read/write response, optional pseudo-random grant stalls, and per-port access counters. Contents are preloadable by hierarchical `$readmemh` into the array `memory`.

---
 rtl/tcdm_dummy_memory.sv | 125 ++++++++++++
 tb/tb_tcdm_dummy_memory.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tcdm_dummy_memory.sv
// tcdm_dummy_memory: multi-port word-addressed TCDM memory model.
// Each of MP ports is a request/grant slave with a registered single-cycle
// response. A per-port 16-bit LFSR can optionally stall grants, and each
// port counts its granted reads and writes.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   enable_i                global grant enable
//   stallable_i             apply the random per-port stall
//   randomize_i             advance the per-port LFSRs this cycle
//   tcdm_req_i   [MP]       request
//   tcdm_add_i   [MP*32]    byte address
//   tcdm_wen_i   [MP]       1 = read, 0 = write
//   tcdm_be_i    [MP*4]     byte enables
//   tcdm_data_i  [MP*32]    write data
//   tcdm_gnt_o   [MP]       grant (combinational)
//   tcdm_r_data_o  [MP*32]  response data (0 for writes / idle)
//   tcdm_r_valid_o [MP]     response valid, one cycle after grant
//   cnt_rd_o, cnt_wr_o [MP*32] granted read / write counters
module tcdm_dummy_memory #(
  parameter int unsigned MP          = 1,
  parameter int unsigned MEMORY_SIZE = 196608,
  parameter logic [31:0] BASE_ADDR   = 32'h1c000000,
  parameter int unsigned PROB_STALL  = 0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              enable_i,
  input  logic              stallable_i,
  input  logic              randomize_i,
  input  logic [MP-1:0]     tcdm_req_i,
  input  logic [MP*32-1:0]  tcdm_add_i,
  input  logic [MP-1:0]     tcdm_wen_i,
  input  logic [MP*4-1:0]   tcdm_be_i,
  input  logic [MP*32-1:0]  tcdm_data_i,
  output logic [MP-1:0]     tcdm_gnt_o,
  output logic [MP*32-1:0]  tcdm_r_data_o,
  output logic [MP-1:0]     tcdm_r_valid_o,
  output logic [MP*32-1:0]  cnt_rd_o,
  output logic [MP*32-1:0]  cnt_wr_o
);

  localparam int unsigned NWORDS    = MEMORY_SIZE / 4;
  localparam int unsigned AW        = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // Storage; left unreset so preloaded contents survive rst_i.
  logic [31:0] memory [NWORDS];

  logic [MP-1:0][15:0] r_lfsr;
  logic [MP-1:0][31:0] r_rdata;
  logic [MP-1:0]       r_rvalid;
  logic [MP-1:0][31:0] r_cnt_rd;
  logic [MP-1:0][31:0] r_cnt_wr;

  logic [MP-1:0][31:0]   w_off;
  logic [MP-1:0][AW-1:0] w_idx;
  logic [MP-1:0]         w_stall;
  logic [MP-1:0]         w_gnt;

  // Address decode, stall and grant per port.
  always_comb begin
    w_off   = '0;
    w_idx   = '0;
    w_stall = '0;
    w_gnt   = '0;
    for (int p = 0; p < int'(MP); p++) begin
      // Offset wraps modulo MEMORY_SIZE, which need not be a power of two.
      w_off[p]   = (tcdm_add_i[p*32 +: 32] - BASE_ADDR) % 32'(MEMORY_SIZE);
      w_idx[p]   = AW'(w_off[p] >> 2);
      w_stall[p] = stallable_i & ({1'b0, r_lfsr[p][7:0]} < 9'(PROB_STALL));
      w_gnt[p]   = tcdm_req_i[p] & enable_i & ~rst_i & ~w_stall[p];
    end
  end

  // Responses, counters and LFSRs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rvalid <= '0;
      r_rdata  <= '0;
      r_cnt_rd <= '0;
      r_cnt_wr <= '0;
      for (int p = 0; p < int'(MP); p++) begin
        r_lfsr[p] <= LFSR_SEED ^ 16'(p);
      end
    end else begin
      for (int p = 0; p < int'(MP); p++) begin
        r_rvalid[p] <= w_gnt[p];
        // Reads see pre-write contents since memory updates at this same edge.
        r_rdata[p]  <= (w_gnt[p] & tcdm_wen_i[p]) ? memory[w_idx[p]] : 32'h0;
        if (w_gnt[p] & tcdm_wen_i[p]) begin
          r_cnt_rd[p] <= r_cnt_rd[p] + 32'd1;
        end
        if (w_gnt[p] & ~tcdm_wen_i[p]) begin
          r_cnt_wr[p] <= r_cnt_wr[p] + 32'd1;
        end
        // Fibonacci LFSR, taps 16,14,13,11.
        if (randomize_i) begin
          r_lfsr[p] <= {r_lfsr[p][0] ^ r_lfsr[p][2] ^ r_lfsr[p][3] ^ r_lfsr[p][5],
                        r_lfsr[p][15:1]};
        end
      end
    end
  end

  // Byte-lane writes; later (higher-index) ports override earlier ones.
  always_ff @(posedge clk_i) begin
    for (int p = 0; p < int'(MP); p++) begin
      if (w_gnt[p] & ~tcdm_wen_i[p]) begin
        for (int b = 0; b < 4; b++) begin
          if (tcdm_be_i[p*4 + b]) begin
            memory[w_idx[p]][8*b +: 8] <= tcdm_data_i[p*32 + 8*b +: 8];
          end
        end
      end
    end
  end

  assign tcdm_gnt_o     = w_gnt;
  assign tcdm_r_data_o  = r_rdata;
  assign tcdm_r_valid_o = r_rvalid;
  assign cnt_rd_o       = r_cnt_rd;
  assign cnt_wr_o       = r_cnt_wr;

endmodule

// File: tb/tb_tcdm_dummy_memory.sv
// Randomized self-checking bench for tcdm_dummy_memory with a behavioural
// per-cycle reference model, plus directed scenarios.
module tb_tcdm_dummy_memory;

  localparam int          MP    = 2;
  localparam int          MEMSZ = 3072;
  localparam logic [31:0] BASE  = 32'h1c000000;
  localparam int          PROB  = 128;
  localparam int          NW    = MEMSZ / 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en  = 1'b0;
  logic             stl = 1'b0;
  logic             rnd = 1'b0;
  logic [MP-1:0]    req = '0;
  logic [MP*32-1:0] add = '0;
  logic [MP-1:0]    wen = '0;
  logic [MP*4-1:0]  be  = '0;
  logic [MP*32-1:0] wdata = '0;
  logic [MP-1:0]    gnt_w;
  logic [MP*32-1:0] rdata_w;
  logic [MP-1:0]    rvalid_w;
  logic [MP*32-1:0] cnt_rd_w;
  logic [MP*32-1:0] cnt_wr_w;

  always #5 clk = ~clk;

  tcdm_dummy_memory #(
    .MP(MP), .MEMORY_SIZE(MEMSZ), .BASE_ADDR(BASE), .PROB_STALL(PROB)
  ) dut (
    .clk_i(clk), .rst_i(rst), .enable_i(en), .stallable_i(stl), .randomize_i(rnd),
    .tcdm_req_i(req), .tcdm_add_i(add), .tcdm_wen_i(wen), .tcdm_be_i(be),
    .tcdm_data_i(wdata), .tcdm_gnt_o(gnt_w), .tcdm_r_data_o(rdata_w),
    .tcdm_r_valid_o(rvalid_w), .cnt_rd_o(cnt_rd_w), .cnt_wr_o(cnt_wr_w)
  );

  // Reference model state.
  logic [31:0]   mem_m    [NW];
  logic [15:0]   m_lfsr   [MP];
  logic [31:0]   m_cnt_rd [MP];
  logic [31:0]   m_cnt_wr [MP];
  logic [31:0]   m_rdata  [MP];
  logic          m_rvalid [MP];
  logic [MP-1:0] m_gnt;

  int n_checks = 0;
  int n_errors = 0;
  int n_g = 0;   // model-predicted grants (port 0)
  int n_dg = 0;  // observed grants (port 0)
  int n_rv = 0;  // observed r_valid (port 0)
  logic [MP-1:0] last_gnt;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, act, exp);
    end
  endtask

  function automatic int widx(input logic [31:0] a);
    logic [31:0] d;
    d = a - BASE;
    return int'(d % 32'(MEMSZ)) / 4;
  endfunction

  function automatic void model_reset();
    for (int p = 0; p < MP; p++) begin
      m_lfsr[p]   = 16'hACE1 ^ 16'(p);
      m_cnt_rd[p] = 0;
      m_cnt_wr[p] = 0;
      m_rdata[p]  = 0;
      m_rvalid[p] = 1'b0;
    end
  endfunction

  function automatic void calc_gnt();
    for (int p = 0; p < MP; p++) begin
      bit stall;
      stall    = stl && (int'(m_lfsr[p] % 16'd256) < PROB);
      m_gnt[p] = req[p] && en && !rst && !stall;
    end
  endfunction

  function automatic void model_edge();
    if (rst) begin
      model_reset();
      return;
    end
    // All reads sample the contents before this edge's writes.
    for (int p = 0; p < MP; p++) begin
      m_rvalid[p] = m_gnt[p];
      m_rdata[p]  = 0;
      if (m_gnt[p]) begin
        if (wen[p]) begin
          m_rdata[p]  = mem_m[widx(add[p*32 +: 32])];
          m_cnt_rd[p] = m_cnt_rd[p] + 1;
        end else begin
          m_cnt_wr[p] = m_cnt_wr[p] + 1;
        end
      end
    end
    // Ascending order: the highest port wins a shared byte.
    for (int p = 0; p < MP; p++) begin
      if (m_gnt[p] && !wen[p]) begin
        int i;
        i = widx(add[p*32 +: 32]);
        for (int b = 0; b < 4; b++)
          if (be[p*4 + b]) mem_m[i][8*b +: 8] = wdata[p*32 + 8*b +: 8];
      end
    end
    if (rnd)
      for (int p = 0; p < MP; p++)
        m_lfsr[p] = {^(m_lfsr[p] & 16'h002D), m_lfsr[p][15:1]};
  endfunction

  // One clock: called at a falling edge with inputs already applied.
  task automatic step();
    calc_gnt();
    #1;
    check_eq("gnt", 32'(gnt_w), 32'(m_gnt));
    last_gnt = gnt_w;
    n_g  += int'(m_gnt[0]);
    n_dg += int'(gnt_w[0]);
    @(posedge clk);
    model_edge();
    #1;
    n_rv += int'(rvalid_w[0]);
    for (int p = 0; p < MP; p++) begin
      check_eq("r_valid", 32'(rvalid_w[p]), 32'(m_rvalid[p]));
      check_eq("r_data",  rdata_w[p*32 +: 32],  m_rdata[p]);
      check_eq("cnt_rd",  cnt_rd_w[p*32 +: 32], m_cnt_rd[p]);
      check_eq("cnt_wr",  cnt_wr_w[p*32 +: 32], m_cnt_wr[p]);
    end
    @(negedge clk);
  endtask

  task automatic set_port(input int p, input logic r, input logic rd,
                          input logic [31:0] a, input logic [3:0] b, input logic [31:0] d);
    req[p]          = r;
    wen[p]          = rd;
    add[p*32 +: 32] = a;
    be[p*4 +: 4]    = b;
    wdata[p*32 +: 32] = d;
  endtask

  task automatic idle();
    req = '0;
  endtask

  initial begin
    // Preload through the hierarchy before the first clock edge.
    for (int i = 0; i < NW; i++) begin
      logic [31:0] v;
      v = $urandom;
      mem_m[i] = v;
      dut.memory[i] = v;
    end
    mem_m[0] = 32'hDEADBEEF; dut.memory[0] = 32'hDEADBEEF;
    mem_m[1] = 32'hAABBCCDD; dut.memory[1] = 32'hAABBCCDD;
    mem_m[2] = 32'h0BADF00D; dut.memory[2] = 32'h0BADF00D;
    mem_m[7] = 32'h01234567; dut.memory[7] = 32'h01234567;
    model_reset();

    @(negedge clk);
    step();
    step();
    check_eq("rst_rvalid", 32'(rvalid_w), 32'h0);
    rst = 1'b0;
    en  = 1'b1;

    // Basic read of word 0.
    set_port(0, 1'b1, 1'b1, BASE, 4'hF, 32'h0);
    step();
    check_eq("rd_gnt", 32'(last_gnt[0]), 32'h1);
    check_eq("rd_data", rdata_w[31:0], 32'hDEADBEEF);
    check_eq("rd_cnt", cnt_rd_w[31:0], 32'h1);

    // Byte-enabled write then readback.
    set_port(0, 1'b1, 1'b0, BASE + 32'd4, 4'b0101, 32'h11223344);
    step();
    check_eq("wr_valid", 32'(rvalid_w[0]), 32'h1);
    check_eq("wr_resp", rdata_w[31:0], 32'h0);
    check_eq("wr_cnt", cnt_wr_w[31:0], 32'h1);
    set_port(0, 1'b1, 1'b1, BASE + 32'd4, 4'hF, 32'h0);
    step();
    check_eq("be_merge", rdata_w[31:0], 32'hAA22CC44);

    // Both ports write the same byte; highest port wins.
    set_port(0, 1'b1, 1'b0, BASE + 32'd20, 4'b0001, 32'h000000FF);
    set_port(1, 1'b1, 1'b0, BASE + 32'd20, 4'b0001, 32'h0000007F);
    step();
    set_port(1, 1'b0, 1'b1, BASE, 4'h0, 32'h0);
    set_port(0, 1'b1, 1'b1, BASE + 32'd20, 4'hF, 32'h0);
    step();
    check_eq("conflict", 32'(rdata_w[7:0]), 32'h7F);

    // Offset wraps modulo MEMORY_SIZE.
    set_port(0, 1'b1, 1'b1, BASE + 32'(MEMSZ) + 32'd8, 4'hF, 32'h0);
    step();
    check_eq("wrap", rdata_w[31:0], 32'h0BADF00D);

    // Same-cycle read and write of one word: read sees old data.
    set_port(0, 1'b1, 1'b1, BASE + 32'd28, 4'hF, 32'h0);
    set_port(1, 1'b1, 1'b0, BASE + 32'd28, 4'hF, 32'h55AA55AA);
    step();
    check_eq("rd_old", rdata_w[31:0], 32'h01234567);
    idle();

    // Held request under random stalls.
    stl = 1'b1; rnd = 1'b1;
    n_g = 0; n_dg = 0; n_rv = 0;
    set_port(0, 1'b1, 1'b1, BASE + 32'd12, 4'hF, 32'h0);
    for (int c = 0; c < 40; c++) step();
    check_eq("stall_gnt_cnt", 32'(n_dg), 32'(n_g));
    check_eq("stall_rv_cnt", 32'(n_rv), 32'(n_dg));
    stl = 1'b0;
    step();
    check_eq("unstall_gnt", 32'(last_gnt[0]), 32'h1);

    // Reset while a response is pending.
    set_port(0, 1'b1, 1'b1, BASE, 4'hF, 32'h0);
    step();
    rst = 1'b1;
    step();
    check_eq("rst_drop", 32'(rvalid_w[0]), 32'h0);
    check_eq("rst_cnt", cnt_rd_w[31:0], 32'h0);
    rst = 1'b0;
    step();
    check_eq("mem_keep", rdata_w[31:0], 32'hDEADBEEF);

    // Randomized traffic.
    for (int c = 0; c < 1500; c++) begin
      rst = ($urandom_range(0, 49) == 0);
      en  = ($urandom_range(0, 7) != 0);
      stl = $urandom_range(0, 1) == 1;
      rnd = ($urandom_range(0, 3) != 0);
      for (int p = 0; p < MP; p++) begin
        logic [31:0] a;
        case ($urandom_range(0, 3))
          0, 1: a = BASE + 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(0, 3));
          2:    a = BASE + 32'($urandom_range(1, 3)) * 32'(MEMSZ) + 32'($urandom_range(0, 15)) * 4;
          default: a = $urandom;
        endcase
        set_port(p, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, a,
                 4'($urandom_range(0, 15)), $urandom);
      end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
